// File: rtl/serial_nibble_rx_pkg.sv
// Shared types and constants for the serial nibble receiver.
// SERIAL_NIBBLE_RX_PARITY_EN adds the PARITY state to the state enum.
package serial_nibble_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // One extra bit so the counter can reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_nibble_rx_if.sv
// Serial input and parallel load-side outputs of the nibble receiver.
interface serial_nibble_rx_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             frame_err;
    logic             busy;

    modport master (
        output sin, sin_valid,
        input  d, en, frame_err, busy
    );

    modport slave (
        input  sin, sin_valid,
        output d, en, frame_err, busy
    );
endinterface

// File: rtl/serial_nibble_rx_shreg.sv
// Indexed-write shift register: writes bit_in to q[idx] when we is high,
// otherwise holds; asynchronously cleared by reset.
module serial_nibble_rx_shreg #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [CW-1:0]    idx,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (we) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (idx == CW'(i)) begin
                    q[i] <= bit_in;
                end
            end
        end
    end

endmodule

// File: rtl/serial_nibble_rx.sv
// Framed serial-to-parallel receiver feeding an enabled register (d/en).
// Optional parity checking is compiled in with SERIAL_NIBBLE_RX_PARITY_EN.
module serial_nibble_rx
    import serial_nibble_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    serial_nibble_rx_if.slave   bus
);

    localparam int CW = cnt_width(WIDTH);

    rx_state_t        state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] d_q;
    logic             en_q, err_q;
    logic             shift_we, load, err;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    logic             par_bad_q, par_bad_n;
`endif

    serial_nibble_rx_shreg #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shreg (
        .clk    (clk),
        .reset  (reset),
        .we     (shift_we),
        .idx    (cnt_q),
        .bit_in (bus.sin),
        .q      (shreg_q)
    );

    // Everything advances only on qualified samples; otherwise all state holds.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        shift_we = 1'b0;
        load     = 1'b0;
        err      = 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        par_bad_n = par_bad_q;
`endif
        if (bus.sin_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.sin == START_LEVEL) begin
                        state_n = ST_DATA;
                        cnt_n   = '0;
                    end
                end
                ST_DATA: begin
                    shift_we = 1'b1;
                    cnt_n    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                ST_PARITY: begin
                    par_bad_n = bus.sin ^ (^shreg_q);
                    state_n   = ST_STOP;
                end
`endif
                ST_STOP: begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                    if (bus.sin == STOP_LEVEL && !par_bad_q) begin
`else
                    if (bus.sin == STOP_LEVEL) begin
`endif
                        load = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            en_q    <= load;
            err_q   <= err;
            if (load) begin
                d_q <= shreg_q;
            end
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            par_bad_q <= par_bad_n;
`endif
        end
    end

    assign bus.d         = d_q;
    assign bus.en        = en_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Self-checking bench for serial_nibble_rx: directed frame table, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_serial_nibble_rx;

    localparam int W = 4;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_nibble_rx_if #(.WIDTH(W)) bus ();

    serial_nibble_rx #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_d;

    typedef struct {
        logic [W-1:0] data;
        logic         stop_bit;
        logic         par_good;
        int           gap_mode;
        logic         exp_en;
        logic         exp_err;
        logic [W-1:0] exp_d;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Sends one frame (start, data LSB first, optional parity, stop), with
    // invalid gap cycles per gap_mode: 0 none, 1 one per sample, 2 random.
    task automatic applyStimulus(input logic [W-1:0] data, input logic stop_bit, input logic par_good,
                                 input int gap_mode, input logic exp_en, input logic exp_err,
                                 input logic [W-1:0] exp_d, input string tag);
        logic bits [$];
        bit   quiet   = 1'b1;
        bit   busy_ok = 1'b1;
        int   n_gap;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(data[i]);
        if (PAR) bits.push_back((^data) ^ ~par_good);
        bits.push_back(stop_bit);
        for (int k = 0; k < bits.size(); k++) begin
            n_gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            for (int g = 0; g < n_gap; g++) begin
                bus.sin       = 1'($urandom);
                bus.sin_valid = 1'b0;
                tick();
                if (bus.en !== 1'b0 || bus.frame_err !== 1'b0) quiet = 1'b0;
                if (bus.busy !== logic'(k > 0)) busy_ok = 1'b0;
            end
            bus.sin       = bits[k];
            bus.sin_valid = 1'b1;
            tick();
            if (k < bits.size() - 1) begin
                if (bus.en !== 1'b0 || bus.frame_err !== 1'b0) quiet = 1'b0;
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
            end
        end
        bus.sin_valid = 1'b0;
        bus.sin       = 1'b1;
        checkOutput({tag, ".en"},        bus.en,        exp_en);
        checkOutput({tag, ".frame_err"}, bus.frame_err, exp_err);
        checkOutput({tag, ".d"},         bus.d,         exp_d);
        checkOutput({tag, ".busy_end"},  bus.busy,      1'b0);
        checkOutput({tag, ".no_early_strobe"}, quiet,   1'b1);
        checkOutput({tag, ".busy_during"},     busy_ok, 1'b1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] r_data;
        logic         r_stop, r_pg, r_good;
        logic [W-1:0] r_exp_d;

        vecs[0] = '{4'hD, 1'b1, 1'b1, 0, 1'b1, 1'b0, 4'hD};
        vecs[1] = '{4'hD, 1'b1, 1'b1, 1, 1'b1, 1'b0, 4'hD};
        vecs[2] = '{4'h4, 1'b0, 1'b1, 0, 1'b0, 1'b1, 4'hD};
        vecs[3] = '{4'hA, 1'b1, 1'b1, 2, 1'b1, 1'b0, 4'hA};
        vecs[4] = '{4'h0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 4'h0};
        vecs[5] = '{4'hF, 1'b0, 1'b1, 1, 1'b0, 1'b1, 4'h0};
        vecs[6] = '{4'hF, 1'b1, 1'b1, 2, 1'b1, 1'b0, 4'hF};

        reset         = 1'b1;
        bus.sin       = 1'b1;
        bus.sin_valid = 1'b0;
        tick();
        tick();
        checkOutput("reset.d",         bus.d,         '0);
        checkOutput("reset.en",        bus.en,        1'b0);
        checkOutput("reset.frame_err", bus.frame_err, 1'b0);
        checkOutput("reset.busy",      bus.busy,      1'b0);
        reset = 1'b0;
        tick();

        // Frames run back to back: each start bit follows the previous stop edge.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].data, vecs[v].stop_bit, vecs[v].par_good, vecs[v].gap_mode,
                          vecs[v].exp_en, vecs[v].exp_err, vecs[v].exp_d, $sformatf("vec%0d", v));
        end
        last_d = 4'hF;

        tick();
        checkOutput("en_one_cycle", bus.en, 1'b0);

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        applyStimulus(4'h7, 1'b1, 1'b1, 0, 1'b1, 1'b0, 4'h7, "par_good");
        applyStimulus(4'h7, 1'b1, 1'b0, 0, 1'b0, 1'b1, 4'h7, "par_bad");
        last_d = 4'h7;
`endif

        // Abort a frame after two data bits with an asynchronous reset.
        bus.sin_valid = 1'b1;
        bus.sin = 1'b0; tick();
        bus.sin = 1'b1; tick();
        bus.sin = 1'b1; tick();
        checkOutput("pre_abort.busy", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort.busy", bus.busy, 1'b0);
        checkOutput("abort.d",    bus.d,    '0);
        bus.sin_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_abort.en",  bus.en,        1'b0);
        checkOutput("post_abort.err", bus.frame_err, 1'b0);
        applyStimulus(4'h3, 1'b1, 1'b1, 0, 1'b1, 1'b0, 4'h3, "after_abort");
        last_d = 4'h3;

        for (int r = 0; r < 40; r++) begin
            r_data  = W'($urandom);
            r_stop  = ($urandom_range(0, 3) != 0);
            r_pg    = ($urandom_range(0, 3) != 0);
            r_good  = r_stop && (r_pg || !PAR);
            r_exp_d = r_good ? r_data : last_d;
            applyStimulus(r_data, r_stop, r_pg, int'($urandom_range(0, 2)),
                          r_good, !r_good, r_exp_d, $sformatf("rand%0d", r));
            last_d = r_exp_d;
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.sin_valid = 1'b0;
                    bus.sin       = 1'($urandom);
                end else begin
                    bus.sin_valid = 1'b1;
                    bus.sin       = 1'b1;
                end
                tick();
                checkOutput("idle.busy", bus.busy, 1'b0);
            end
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_nibble_rx.md
# serial_nibble_rx

Serial-to-parallel receive stage that assembles framed serial bits into a WIDTH-bit word. It drives the data and load-enable inputs of the downstream enabled, asynchronously reset register. On each correctly framed word it presents the word on `d` and pulses `en` for exactly one cycle. Malformed frames are flagged and never produce a load.

## Interface
Parameters:
- `WIDTH`, default 4: data bits per frame; matches downstream register width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `sin`, in, 1: serial line; idle level 1.
- `sin_valid`, in, 1: qualifies `sin`; the line is sampled only in cycles where this is 1.
- `d`, out, WIDTH: last good word, registered; feeds the downstream register's `d`.
- `en`, out, 1: one-cycle load strobe; feeds the downstream register's `en`.
- `frame_err`, out, 1: one-cycle pulse on a bad stop bit or, when compiled in, a bad parity bit.
- `busy`, out, 1: high while a frame is in progress (state ≠ IDLE).

## Operation
FSM states are IDLE, DATA, PARITY (only with `SERIAL_NIBBLE_RX_PARITY_EN`) and STOP. Transitions are evaluated only in cycles with `sin_valid`=1; otherwise all state, counter and shift register are held.
- IDLE:
  - `sin`=0 (start bit) → DATA, bit counter cleared.
  - `sin`=1 → stay in IDLE.
- DATA:
  - Each sample writes `sin` into shift register bit [cnt], LSB first, and increments cnt.
  - After sample WIDTH-1 → PARITY if compiled in, else STOP.
- PARITY:
  - Sample compared against the XOR of the data bits (even parity overall); the result is stored as `par_bad`.
  - Always → STOP.
- STOP:
  - `sin`=1 and not `par_bad` → load `d` from the shift register, assert `en` next cycle, → IDLE.
  - Otherwise → pulse `frame_err`, leave `d` unchanged, → IDLE.
- Bad stop bit: no resynchronisation hunt. If a 0 stop bit is sampled, the next `sin`=0 sample in IDLE is treated as a fresh start bit.
- Back-to-back frames: a start bit sampled in the cycle immediately after STOP → IDLE is accepted.
- `en` and `frame_err` are never high in the same cycle.
- The bit counter is $clog2(WIDTH)+1 bits wide and never wraps mid-frame.

## Timing
- Reset values: state=IDLE, cnt=0, shift register=0, `d`=0, `en`=0, `frame_err`=0, `busy`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency with `sin_valid` continuously high and the start bit sampled at edge t:
  - Data bits sampled at t+1..t+WIDTH.
  - Stop bit sampled at t+WIDTH+1 (t+WIDTH+2 with parity).
  - `en`, the new `d` and `frame_err` become visible after the stop-bit sampling edge and stay for one cycle: at t+6 with WIDTH=4, no parity.
- `d` changes only together with an `en` pulse and holds between good frames.
- `busy` rises the cycle after the start-bit sample and falls in the same cycle `en` or `frame_err` rises.
- Reset asserted mid-frame aborts immediately: no `en`, no `frame_err`, outputs return to reset values.

## Configuration
- `SERIAL_NIBBLE_RX_PARITY_EN` defined:
  - The PARITY state exists and frames are WIDTH+3 bits long.
  - A parity mismatch raises `frame_err` at the stop-bit sample even when the stop bit is good.
- Not defined:
  - PARITY state and `par_bad` are absent; frames are WIDTH+2 bits long.
  - `frame_err` reports only a bad stop bit.

## Structure
- Shared package `serial_nibble_rx_pkg`: state enum type (`rx_state_t`), start/stop/idle level constants, and the counter-width function.
- One sub-module is natural: `serial_nibble_rx_shreg`, an indexed-write shift register with hold-on-invalid, WIDTH parameter, reset to 0.

## Test plan
- Reset state: assert `reset` → `d`=0, `en`=0, `frame_err`=0, `busy`=0.
- Good frame, no parity: `sin_valid`=1 every cycle, send 0,1,0,1,1,1 (start, data LSB-first 1101b, stop) → one `en` pulse 6 cycles after start, `d`=4'hD, `busy` high for 5 cycles.
- Gapped `sin_valid`: same frame with `sin_valid` low every other cycle → same `d`=4'hD, `en` delayed accordingly, no spurious sampling.
- Bad stop bit: frame 0,0,0,1,0,0 → `frame_err` pulse, `en` stays 0, `d` keeps its previous value 4'hD.
- Reset mid-frame: assert `reset` after 2 data bits, then send a clean frame for 4'h3 → no `en` from the aborted frame, `d`=4'h3 after the clean one.
- Parity build (`SERIAL_NIBBLE_RX_PARITY_EN`): data 4'h7 with parity bit 1 → `en`, `d`=4'h7; the same frame with parity bit 0 → `frame_err`, no `en`.
